// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage CPU.
//
// Each cycle it decides whether the PC and the IF/ID, ID/EX, EX/MEM and
// MEM/WB registers advance, hold, or take a bubble/flush. Data hazards use
// 3-bit register tags; r0 is never a hazard.
//
// The controller covers three situations:
//   - load-use and branch-operand stalls;
//   - the data-memory wait handshake, with a timeout;
//   - the halt/drain sequence.
//
// It also keeps saturating stall and flush statistics.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ID_*                tags/flags of the instruction in decode
//   EX_*, MEM_*         destination tags and flags of the later stages
//   dmem_ready          data memory completes its access this cycle
//   dmem_req            data memory request
//   PC_Write..EXMEM_Write   pipeline register write enables (combinational)
//   IFID_Flush, IDEX_Bubble, MEMWB_Bubble   NOP insertion selects (combinational)
//   done, mem_err       halted / halted by memory timeout (registered)
//   stall_cnt, flush_cnt    saturating statistics (registered)
module hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       ID_Rs,
  input  logic [2:0]       ID_Rd,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRd,
  input  logic             ID_IsBranch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Halt,
  input  logic [2:0]       EX_Rd,
  input  logic [2:0]       MEM_Rd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemAccess,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             MEMWB_Bubble,
  output logic             done,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [TW-1:0]    WAIT_LAST  = TW'(MEM_TIMEOUT - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             done_q, done_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use_s;
  logic br_haz_s;
  logic freeze_s;
  logic stall_s;

  // Hazard detection on register tags; r0 is hard-wired and never a producer.
  assign load_use_s = EX_MemRead && (EX_Rd != 3'd0) &&
                      ((ID_UsesRs && (EX_Rd == ID_Rs)) ||
                       (ID_UsesRd && (EX_Rd == ID_Rd)));

  // Branches resolve in ID, so they also wait on an ALU result still in EX
  // and on load data that has not come back from MEM yet.
  assign br_haz_s = ID_IsBranch &&
                    ((EX_RegWrite && (EX_Rd != 3'd0) && (EX_Rd == ID_Rs)) ||
                     (MEM_MemRead && (MEM_Rd != 3'd0) && (MEM_Rd == ID_Rs)));

  // State register, timers, sticky status flags and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state and pipeline control: freeze > stall > flush > halt.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    done_d       = done_q;
    mem_err_d    = mem_err_q;
    freeze_s     = 1'b0;
    stall_s      = 1'b0;
    dmem_req     = 1'b0;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    EXMEM_Write  = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    MEMWB_Bubble = 1'b0;

    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (state_q == S_MEM_WAIT) begin
          dmem_req = 1'b1;
          freeze_s = !dmem_ready;
        end else begin
          dmem_req = MEM_MemAccess;
          freeze_s = MEM_MemAccess && !dmem_ready;
        end

        if (freeze_s) begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          IDEX_Write   = 1'b0;
          EXMEM_Write  = 1'b0;
          MEMWB_Bubble = 1'b1;
          if (state_q == S_RUN) begin
            state_d    = S_MEM_WAIT;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            // Memory never answered: stop the machine and flag it.
            state_d   = S_HALT;
            done_d    = 1'b1;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + TW'(1);
          end
        end else begin
          // The completing MEM_WAIT cycle behaves like an ordinary RUN cycle.
          state_d    = S_RUN;
          wait_cnt_d = '0;
          if (load_use_s || br_haz_s) begin
            stall_s     = 1'b1;
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end else if (ID_IsBranch && ID_BranchTaken) begin
            IFID_Flush = 1'b1;
          end else if (ID_Halt) begin
            // Halt leaves ID: stop fetching, let older instructions retire.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_DRAIN: begin
        dmem_req   = MEM_MemAccess;
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        freeze_s   = MEM_MemAccess && !dmem_ready;
        if (freeze_s) begin
          // Drain count pauses; the memory wait is still bounded.
          IDEX_Write   = 1'b0;
          EXMEM_Write  = 1'b0;
          MEMWB_Bubble = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = S_HALT;
            done_d    = 1'b1;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + TW'(1);
          end
        end else begin
          IDEX_Bubble = 1'b1;
          wait_cnt_d  = '0;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + DW'(1);
          end
        end
      end

      S_HALT: begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Write  = 1'b0;
        EXMEM_Write = 1'b0;
        done_d      = 1'b1;
      end

      default: begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Write  = 1'b0;
        EXMEM_Write = 1'b0;
        state_d     = S_RUN;
      end
    endcase
  end

  // Saturating statistics: stall counts freeze and stall cycles alike.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze_s || stall_s) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (IFID_Flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  assign done      = done_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage CPU: decides each cycle whether each pipeline register advances, holds, or takes a bubble/flush, using the same 3-bit register-tag comparisons (r0 never a hazard) as the forwarding path. It covers load-use and branch-operand stalls, the data-memory wait handshake with timeout, and the halt/drain sequence. It also maintains stall and flush statistics. It sits beside the forwarding logic, driving write-enables and bubble/flush selects into IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- MEM_TIMEOUT, 16: max cycles in MEM_WAIT before error halt (≥2)
- DRAIN_CYCLES, 3: cycles from halt acceptance to done (≥1)
- CNT_W, 16: statistics counter width
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- ID_Rs, ID_Rd  in  3  source tags of instruction in ID (Rd is also read)
- ID_UsesRs, ID_UsesRd, ID_IsBranch, ID_BranchTaken, ID_Halt  in  1  decode flags
- EX_Rd, MEM_Rd  in  3  destination tags
- EX_RegWrite, EX_MemRead, MEM_MemRead, MEM_MemAccess  in  1  stage flags
- dmem_ready  in  1  data memory completes access this cycle
- dmem_req  out  1  data memory request
- PC_Write, IFID_Write, IDEX_Write, EXMEM_Write  out  1  register enables
- IFID_Flush, IDEX_Bubble, MEMWB_Bubble  out  1  insert NOP
- done, mem_err  out  1  halted / halted by timeout
- stall_cnt, flush_cnt  out  CNT_W  saturating statistics

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALT.
- freeze = (RUN & MEM_MemAccess & !dmem_ready) | (MEM_WAIT & !dmem_ready).
- load_use = EX_MemRead & EX_Rd≠0 & ((ID_UsesRs & EX_Rd==ID_Rs) | (ID_UsesRd & EX_Rd==ID_Rd)).
- br_haz = ID_IsBranch & ((EX_RegWrite & EX_Rd≠0 & EX_Rd==ID_Rs) | (MEM_MemRead & MEM_Rd≠0 & MEM_Rd==ID_Rs)).
- Priority: freeze > (load_use | br_haz) > branch flush > halt.
- freeze: PC_Write=IFID_Write=IDEX_Write=EXMEM_Write=0, MEMWB_Bubble=1; other bubbles/flush 0.
- stall (load_use|br_haz, no freeze): PC_Write=IFID_Write=0, IDEX_Bubble=1, IDEX_Write=EXMEM_Write=1.
- flush (ID_IsBranch & ID_BranchTaken, no stall/freeze): IFID_Flush=1, all enables 1.
- Default in RUN: all enables 1, all bubbles/flush 0.
- dmem_req = MEM_MemAccess in RUN, 1 throughout MEM_WAIT.
- RUN→MEM_WAIT on MEM_MemAccess & !dmem_ready; MEM_WAIT→RUN on dmem_ready (freeze deasserted that cycle).
- MEM_WAIT timer counts cycles; reaching MEM_TIMEOUT without dmem_ready → HALT with mem_err=1.
- RUN→DRAIN on ID_Halt with no freeze/stall: that cycle PC_Write=IFID_Write=0, IDEX_Bubble=1. In DRAIN, PC_Write=IFID_Write=0 and IDEX_Bubble=1; later stages advance; a MEM_MemAccess in DRAIN still freezes (timer paused, not reset). DRAIN lasts DRAIN_CYCLES unfrozen cycles → HALT.
- HALT: all enables 0, dmem_req=0, done=1; only reset leaves it.
- stall_cnt +1 per cycle with freeze or stall; flush_cnt +1 per IFID_Flush; both saturate at 2^CNT_W−1.

## Timing
- Reset: state RUN, timers 0, done=0, mem_err=0, stall_cnt=flush_cnt=0. Enables/bubbles are combinational from state and inputs (RUN, idle inputs: all enables 1).
- State, counters, done, mem_err update on posedge clk; done/mem_err rise the cycle after the transition-causing edge.
- Load-use stall lasts exactly 1 cycle (load advances to MEM). br_haz on an EX ALU producer lasts 1 cycle; on an EX load lasts 2 cycles (EX term, then MEM_MemRead term).
- dmem_ready in the same cycle as MEM_MemAccess: zero-wait, no freeze, stays in RUN.
- Timeout: with dmem_ready never asserted, HALT entered on the edge ending cycle MEM_TIMEOUT of MEM_WAIT.
- Simultaneous ID_Halt and ID_BranchTaken: flush wins; halt ignored.
- rst_n asserted mid-MEM_WAIT or DRAIN: immediate return to reset values.

## Test plan
- Load r3 in EX, ID reads r3 as Rs → exactly one cycle PC_Write=0, IDEX_Bubble=1; stall_cnt=1. Same with tag r0 → no stall.
- Branch on r2 with ALU write r2 in EX → 1 stall cycle; with load r2 in EX → 2 stall cycles; then taken → IFID_Flush one cycle, flush_cnt=1.
- MEM_MemAccess, dmem_ready low 3 cycles → dmem_req high 4 cycles, freeze 3 cycles, back to RUN; zero-wait case → no freeze.
- dmem_ready held low, MEM_TIMEOUT=16 → HALT after 16 MEM_WAIT cycles, done=1, mem_err=1, all enables 0.
- ID_Halt, DRAIN_CYCLES=3, no memory ops → done=1 on 4th edge after acceptance, mem_err=0; with a 2-cycle memory wait in DRAIN → done delayed 2 cycles.
- rst_n low mid-MEM_WAIT → state RUN, counters 0, done=0 asynchronously; 2^CNT_W stall cycles → stall_cnt holds at max.
